// File: rtl/updown_counter_modn.sv
// rtl/updown_counter_modn.sv - up/down counter with programmable modulus, wrap/saturate, cascade tc
// Optional tick prescaler enabled by defining COUNTER_PRESCALER_EN.
module updown_counter_modn #(
  parameter int NBITS    = 4,
  parameter int MODULO   = 10,
  parameter int PRESCALE = 4
) (
  input  logic             clk_2,
  input  logic             reset,
  input  logic             load,
  input  logic [NBITS-1:0] data_in,
  input  logic             enable,
  input  logic             count_up,
  input  logic             sat_mode,
  output logic [NBITS-1:0] count,
  output logic             tc,
  output logic             wrap_pulse,
  output logic             saturated,
  output logic             load_err
);

  localparam logic [NBITS-1:0] MAX_VAL = NBITS'(MODULO - 1);

  logic [NBITS-1:0] r_count;
  logic             r_wrap_pulse;
  logic             r_saturated;
  logic             r_load_err;

  logic             w_tick;
  logic             w_step;
  logic             w_at_top;
  logic             w_at_bot;
  logic             w_load_ok;
  logic [NBITS-1:0] w_count_nxt;
  logic             w_wrap;
  logic             w_block;

`ifdef COUNTER_PRESCALER_EN
  localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(PRESCALE - 1);

  logic [PRE_W-1:0] r_pre;

  // Prescaler only advances on enabled cycles so a stalled cascade keeps its phase.
  always_ff @(posedge clk_2 or posedge reset) begin
    if (reset) begin
      r_pre <= '0;
    end else if (load) begin
      r_pre <= '0;
    end else if (enable) begin
      r_pre <= w_tick ? '0 : r_pre + 1'b1;
    end
  end

  assign w_tick = (r_pre == PRE_MAX);
`else
  assign w_tick = 1'b1;
`endif

  assign w_step   = enable & w_tick;
  assign w_at_top = (r_count == MAX_VAL);
  assign w_at_bot = (r_count == '0);
  // Widened compare keeps MODULO == 2**NBITS from truncating to zero.
  assign w_load_ok = ({1'b0, data_in} < (NBITS+1)'(MODULO));

  always_comb begin
    w_count_nxt = r_count;
    w_wrap      = 1'b0;
    w_block     = 1'b0;
    if (w_step) begin
      if (count_up) begin
        if (!w_at_top) begin
          w_count_nxt = r_count + 1'b1;
        end else if (sat_mode) begin
          w_block = 1'b1;
        end else begin
          w_count_nxt = '0;
          w_wrap      = 1'b1;
        end
      end else begin
        if (!w_at_bot) begin
          w_count_nxt = r_count - 1'b1;
        end else if (sat_mode) begin
          w_block = 1'b1;
        end else begin
          w_count_nxt = MAX_VAL;
          w_wrap      = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_2 or posedge reset) begin
    if (reset) begin
      r_count      <= '0;
      r_wrap_pulse <= 1'b0;
      r_saturated  <= 1'b0;
      r_load_err   <= 1'b0;
    end else if (load) begin
      r_count      <= w_load_ok ? data_in : MAX_VAL;
      r_wrap_pulse <= 1'b0;
      r_saturated  <= 1'b0;
      if (!w_load_ok) begin
        r_load_err <= 1'b1;
      end
    end else begin
      r_count      <= w_count_nxt;
      r_wrap_pulse <= w_wrap;
      if (w_block) begin
        r_saturated <= 1'b1;
      end
    end
  end

  // Terminal count stays asserted at the end value in sat mode so an upper stage sees the attempt.
  assign tc         = w_step & (count_up ? w_at_top : w_at_bot);
  assign count      = r_count;
  assign wrap_pulse = r_wrap_pulse;
  assign saturated  = r_saturated;
  assign load_err   = r_load_err;

endmodule
